// File: rtl/demux_scatter_n_if.sv
// Bundle of handshake and data signals for the 1-to-N scatter demux.
//   master : the beat producer and frame consumer (drives beats, clear, consume)
//   slave  : the demux (drives in_ready, the frame outputs, sel_err)
//   mode_seq/select/in_data/in_valid/in_ready : input beat handshake and routing
//   clear/out_consume                         : frame abort / frame taken
//   out_data/out_valid/frame_full/sel_err     : frame outputs toward the array
interface demux_scatter_n_if #(
    parameter int NUM_CHANNELS = 32,
    parameter int SELECT_WIDTH = $clog2(NUM_CHANNELS),
    parameter int DATA_WIDTH   = 16
);
    logic                               mode_seq;
    logic [SELECT_WIDTH-1:0]            select;
    logic [DATA_WIDTH-1:0]              in_data;
    logic                               in_valid;
    logic                               in_ready;
    logic                               clear;
    logic                               out_consume;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data;
    logic [NUM_CHANNELS-1:0]            out_valid;
    logic                               frame_full;
    logic                               sel_err;

    modport master (
        output mode_seq, select, in_data, in_valid, clear, out_consume,
        input  in_ready, out_data, out_valid, frame_full, sel_err
    );

    modport slave (
        input  mode_seq, select, in_data, in_valid, clear, out_consume,
        output in_ready, out_data, out_valid, frame_full, sel_err
    );
endinterface

// File: rtl/demux_scatter_n.sv
// Registered 1-to-N scatter demux. Each accepted beat is written into one
// per-channel holding register, chosen either by select (addressed mode) or by
// an auto-incrementing pointer (sequential mode). Once every channel is loaded
// the frame is held (in_ready low) until the array consumes it or it is cleared.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : demux_scatter_n_if.slave (beat handshake in, frame out)

// One channel holding register plus its loaded flag.
//   wr_i      : store data_i this edge (wins over clr_i, so a beat landing on
//               a consume edge leaves the channel loaded)
//   clr_i     : drop the loaded flag; data is kept
//   vld_nxt_o : next-state of the loaded flag, used for frame-full detection
module demux_scatter_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  vld_o,
    output logic                  vld_nxt_o
);
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  vld_q, vld_d;

    always_comb begin
        data_d = wr_i ? data_i : data_q;
        vld_d  = wr_i | (vld_q & ~clr_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign data_o    = data_q;
    assign vld_o     = vld_q;
    assign vld_nxt_o = vld_d;
endmodule

module demux_scatter_n #(
    parameter int NUM_CHANNELS = 32,
    parameter int SELECT_WIDTH = $clog2(NUM_CHANNELS),
    parameter int DATA_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst,
    demux_scatter_n_if.slave    bus
);
    localparam logic [SELECT_WIDTH:0]   NUM_CH_W = (SELECT_WIDTH+1)'(NUM_CHANNELS);
    localparam logic [SELECT_WIDTH-1:0] PTR_LAST = SELECT_WIDTH'(NUM_CHANNELS-1);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [SELECT_WIDTH-1:0]  ptr_q, ptr_d;
    logic                     sel_err_q, sel_err_d;

    logic                     flush, accept, beat, sel_bad;
    logic [SELECT_WIDTH-1:0]  ptr_base, chan;
    logic [NUM_CHANNELS-1:0]  wr_vec, vld_w, vld_nxt;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] data_w;

    // consume and clear both empty the frame; clear additionally kills the beat
    assign flush   = bus.clear | bus.out_consume;
    assign accept  = bus.in_valid & (state_q == FILL);
    assign beat    = accept & ~bus.clear;
    // a beat on a consume edge is applied after the pointer reset
    assign ptr_base = bus.out_consume ? '0 : ptr_q;
    assign chan     = bus.mode_seq ? ptr_base : bus.select;
    assign sel_bad  = ~bus.mode_seq & ({1'b0, bus.select} >= NUM_CH_W);

    genvar i;
    generate
        for (i = 0; i < NUM_CHANNELS; i++) begin : g_lane
            localparam logic [SELECT_WIDTH-1:0] IDX = SELECT_WIDTH'(i);
            assign wr_vec[i] = beat & ~sel_bad & (chan == IDX);
            demux_scatter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
                .clk       (clk),
                .rst       (rst),
                .wr_i      (wr_vec[i]),
                .clr_i     (flush),
                .data_i    (bus.in_data),
                .data_o    (data_w[i]),
                .vld_o     (vld_w[i]),
                .vld_nxt_o (vld_nxt[i])
            );
        end
    endgenerate

    always_comb begin
        ptr_d     = ptr_q;
        sel_err_d = beat & sel_bad;
        state_d   = state_q;
        if (flush)
            ptr_d = '0;
        if (beat & bus.mode_seq)
            ptr_d = (ptr_base == PTR_LAST) ? '0 : ptr_base + SELECT_WIDTH'(1);
        case (state_q)
            FILL:    if (&vld_nxt) state_d = FULL;
            FULL:    if (flush)    state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            ptr_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.out_data   = data_w;
    assign bus.out_valid  = vld_w;
    assign bus.in_ready   = (state_q == FILL);
    assign bus.frame_full = (state_q == FULL);
    assign bus.sel_err    = sel_err_q;
endmodule

// File: tb/tb_demux_scatter_n.sv
// Bench for demux_scatter_n: a 4-channel and a 5-channel instance, each
// tracked by a frame-level model (array of words + loaded flags + pointer).
// A negedge process compares every output of both instances to the model each
// cycle; directed sequences add hand-computed literal checks.
module tb_demux_scatter_n;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_scatter_n_if #(.NUM_CHANNELS(4), .SELECT_WIDTH(2), .DATA_WIDTH(16)) b4 ();
    demux_scatter_n_if #(.NUM_CHANNELS(5), .SELECT_WIDTH(3), .DATA_WIDTH(16)) b5 ();

    demux_scatter_n #(.NUM_CHANNELS(4), .SELECT_WIDTH(2), .DATA_WIDTH(16)) u4 (
        .clk(clk), .rst(rst), .bus(b4));
    demux_scatter_n #(.NUM_CHANNELS(5), .SELECT_WIDTH(3), .DATA_WIDTH(16)) u5 (
        .clk(clk), .rst(rst), .bus(b5));

    // stimulus, index 0 -> 4-channel instance, 1 -> 5-channel instance
    logic        mode [2];
    logic [2:0]  sel  [2];
    logic [15:0] din  [2];
    logic        vin  [2];
    logic        clr  [2];
    logic        cons [2];

    assign b4.mode_seq = mode[0];  assign b5.mode_seq = mode[1];
    assign b4.select   = sel[0][1:0]; assign b5.select = sel[1];
    assign b4.in_data  = din[0];   assign b5.in_data  = din[1];
    assign b4.in_valid = vin[0];   assign b5.in_valid = vin[1];
    assign b4.clear    = clr[0];   assign b5.clear    = clr[1];
    assign b4.out_consume = cons[0]; assign b5.out_consume = cons[1];

    // model
    logic [15:0] md [2][8];
    bit          mv [2][8];
    int          mp [2];
    bit          mf [2];
    bit          me [2];
    int          nc [2];

    int nvec = 0;
    int nbad = 0;
    bit run  = 0;

    task automatic chk(string nm, logic [79:0] a, logic [79:0] e);
        nvec++;
        if (a !== e) begin
            nbad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 8; c++) begin
                md[d][c] = '0;
                mv[d][c] = 0;
            end
            mp[d] = 0; mf[d] = 0; me[d] = 0;
        end
    endtask

    // frame rules: clear drops everything incl. the beat; consume empties the
    // frame and then any accepted beat lands; full means every channel loaded
    task automatic model_step(int d);
        bit acc;
        int ch;
        acc   = vin[d] && !mf[d];
        me[d] = 0;
        if (clr[d]) begin
            for (int c = 0; c < 8; c++) mv[d][c] = 0;
            mp[d] = 0;
        end else begin
            if (cons[d]) begin
                for (int c = 0; c < 8; c++) mv[d][c] = 0;
                mp[d] = 0;
            end
            if (acc) begin
                if (mode[d]) begin
                    ch    = mp[d];
                    mp[d] = (mp[d] + 1) % nc[d];
                end else begin
                    ch = int'(sel[d]) & ((d == 0) ? 3 : 7);
                end
                if (ch < nc[d]) begin
                    md[d][ch] = din[d];
                    mv[d][ch] = 1;
                end else begin
                    me[d] = 1;
                end
            end
        end
        mf[d] = 1;
        for (int c = 0; c < nc[d]; c++) if (!mv[d][c]) mf[d] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    // per-cycle comparison against the model
    logic [79:0] c_ad, c_ed;
    logic [4:0]  c_av, c_ev;
    logic        c_r, c_f, c_e;
    always @(negedge clk) begin
        if (!rst && run) begin
            for (int d = 0; d < 2; d++) begin
                c_ed = '0; c_ev = '0;
                for (int c = 0; c < nc[d]; c++) begin
                    c_ed[c*16 +: 16] = md[d][c];
                    c_ev[c]          = mv[d][c];
                end
                if (d == 0) begin
                    c_ad = 80'(b4.out_data); c_av = 5'(b4.out_valid);
                    c_r = b4.in_ready; c_f = b4.frame_full; c_e = b4.sel_err;
                end else begin
                    c_ad = b5.out_data; c_av = b5.out_valid;
                    c_r = b5.in_ready; c_f = b5.frame_full; c_e = b5.sel_err;
                end
                chk($sformatf("dut%0d out_data", d),   c_ad, c_ed);
                chk($sformatf("dut%0d out_valid", d),  80'(c_av), 80'(c_ev));
                chk($sformatf("dut%0d in_ready", d),   80'(c_r), 80'(!mf[d]));
                chk($sformatf("dut%0d frame_full", d), 80'(c_f), 80'(mf[d]));
                chk($sformatf("dut%0d sel_err", d),    80'(c_e), 80'(me[d]));
            end
        end
    end

    initial begin
        nc[0] = 4; nc[1] = 5;
        for (int d = 0; d < 2; d++) begin
            mode[d] = 0; sel[d] = '0; din[d] = '0; vin[d] = 0; clr[d] = 0; cons[d] = 0;
        end
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset in_ready",   80'(b4.in_ready),   80'(1));
        chk("reset frame_full", 80'(b4.frame_full), 80'(0));
        chk("reset out_valid",  80'(b5.out_valid),  80'(0));
        rst = 1'b0;
        run = 1;

        // 1: sequential fill of 4 channels
        mode[0] = 1; vin[0] = 1;
        for (int k = 1; k <= 4; k++) begin
            din[0] = 16'(16'h1111 * k);
            tick();
        end
        chk("t1 data",  80'(b4.out_data),   80'h4444_3333_2222_1111);
        chk("t1 valid", 80'(b4.out_valid),  80'hF);
        chk("t1 full",  80'(b4.frame_full), 80'(1));
        chk("t1 ready", 80'(b4.in_ready),   80'(0));

        // 2: stall in FULL, then consume
        din[0] = 16'h5555;
        repeat (3) tick();
        chk("t2 stall data",  80'(b4.out_data),  80'h4444_3333_2222_1111);
        chk("t2 stall valid", 80'(b4.out_valid), 80'hF);
        cons[0] = 1; tick(); cons[0] = 0;
        chk("t2 consumed valid", 80'(b4.out_valid), 80'(0));
        chk("t2 consumed ready", 80'(b4.in_ready),  80'(1));
        tick();
        vin[0] = 0;
        chk("t2 ch0", 80'(b4.out_data[15:0]), 80'h5555);
        chk("t2 v",   80'(b4.out_valid),      80'h1);
        cons[0] = 1; tick(); cons[0] = 0;

        // 3: addressed writes, overwrite of ch2
        mode[0] = 0; vin[0] = 1;
        sel[0] = 3'd2; din[0] = 16'hFFFB; tick();
        chk("t3 ch2 neg", 80'(b4.out_data[47:32]), 80'hFFFB);
        sel[0] = 3'd2; din[0] = 16'h0007; tick();
        sel[0] = 3'd0; din[0] = 16'h00A0; tick();
        sel[0] = 3'd1; din[0] = 16'h00A1; tick();
        chk("t3 not full", 80'(b4.frame_full), 80'(0));
        sel[0] = 3'd3; din[0] = 16'h00A3; tick();
        vin[0] = 0;
        chk("t3 full", 80'(b4.frame_full), 80'(1));
        chk("t3 ch2",  80'(b4.out_data[47:32]), 80'h0007);
        cons[0] = 1; tick(); cons[0] = 0;

        // mode change mid-frame keeps pointer and loaded channels
        mode[0] = 1; vin[0] = 1;
        din[0] = 16'h00B0; tick();
        din[0] = 16'h00B1; tick();
        mode[0] = 0; sel[0] = 3'd3; din[0] = 16'h00B3; tick();
        mode[0] = 1; din[0] = 16'h00B2; tick();
        vin[0] = 0;
        chk("mc valid", 80'(b4.out_valid), 80'hF);
        chk("mc data",  80'(b4.out_data),  80'h00B3_00B2_00B1_00B0);
        cons[0] = 1; tick(); cons[0] = 0;

        // consume in FILL with a beat on the same edge
        vin[0] = 1;
        din[0] = 16'h00C0; tick();
        din[0] = 16'h00C1; tick();
        cons[0] = 1; din[0] = 16'hBEEF; tick(); cons[0] = 0;
        chk("cb valid", 80'(b4.out_valid),      80'h1);
        chk("cb ch0",   80'(b4.out_data[15:0]), 80'hBEEF);
        din[0] = 16'hCAFE; tick();
        vin[0] = 0;
        chk("cb valid2", 80'(b4.out_valid),       80'h3);
        chk("cb ch1",    80'(b4.out_data[31:16]), 80'hCAFE);

        // 5: clear on the same edge as a beat
        clr[0] = 1; tick(); clr[0] = 0;
        vin[0] = 1;
        din[0] = 16'h00D0; tick();
        din[0] = 16'h00D1; tick();
        clr[0] = 1; din[0] = 16'hDEAD; tick(); clr[0] = 0;
        vin[0] = 0;
        chk("t5 valid", 80'(b4.out_valid),       80'h0);
        chk("t5 ch2",   80'(b4.out_data[47:32]), 80'h00B2);
        vin[0] = 1; din[0] = 16'h00E0; tick(); vin[0] = 0;
        chk("t5 ch0",   80'(b4.out_data[15:0]), 80'h00E0);
        chk("t5 v0",    80'(b4.out_valid),      80'h1);

        // 4: out-of-range select on the 5-channel instance
        mode[1] = 0; sel[1] = 3'd6; din[1] = 16'h1234; vin[1] = 1; tick(); vin[1] = 0;
        chk("t4 sel_err", 80'(b5.sel_err),   80'(1));
        chk("t4 valid",   80'(b5.out_valid), 80'(0));
        chk("t4 data",    80'(b5.out_data),  80'(0));
        tick();
        chk("t4 sel_err drop", 80'(b5.sel_err), 80'(0));
        sel[1] = 3'd4; din[1] = 16'h4444; vin[1] = 1; tick();
        chk("t4 ch4", 80'(b5.out_data[79:64]), 80'h4444);
        chk("t4 v4",  80'(b5.out_valid),       80'h10);
        clr[1] = 1; sel[1] = 3'd7; tick(); clr[1] = 0; vin[1] = 0;
        chk("t4 clr no err", 80'(b5.sel_err),   80'(0));
        chk("t4 clr valid",  80'(b5.out_valid), 80'(0));

        // 6: asynchronous reset mid-fill
        vin[0] = 1;
        din[0] = 16'h00F0; tick();
        din[0] = 16'h00F1; tick();
        vin[0] = 0;
        #2 rst = 1'b1;
        #1;
        chk("t6 data",  80'(b4.out_data),  80'(0));
        chk("t6 valid", 80'(b4.out_valid), 80'(0));
        chk("t6 ready", 80'(b4.in_ready),  80'(1));
        chk("t6 data5", 80'(b5.out_data),  80'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        vin[0] = 1; din[0] = 16'h00F5; tick(); vin[0] = 0;
        chk("t6 ch0", 80'(b4.out_data), 80'h00F5);
        chk("t6 v0",  80'(b4.out_valid), 80'h1);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
